// File: rtl/core_pkg.sv
// Shared defaults, FSM state encoding and sizing helper for the core accumulator writer.
// No logic; imported by core_acc_writer and core_wfifo.
package core_pkg;

    localparam int RES_W_DEF      = 16;
    localparam int PACK_DEF       = 4;
    localparam int ADDR_W_DEF     = 10;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/core_wfifo.sv
// Show-ahead FIFO of packed write words: head visible while non-empty, count registered.
// Push is ignored when full, pop is ignored when empty; DEPTH must be a power of two >= 2.
module core_wfifo
    import core_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = FIFO_DEPTH_DEF,
    localparam int AW   = idx_w(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          push_i,
    input  logic [W-1:0]  push_dat_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_dat_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign do_push    = push_i && (count_q != CW'(DEPTH));
    assign do_pop     = pop_i && (count_q != '0);
    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/core_acc_writer.sv
// Packs PACK core results per word and writes them to consecutive global-buffer addresses.
// A word reaches the bus 2 cycles after its last lane; res_ready drops while a word is pending or the FIFO is full.
module core_acc_writer
    import core_pkg::*;
#(
    parameter int RES_W      = RES_W_DEF,
    parameter int PACK       = PACK_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [15:0]           len,
    output logic                  busy,
    output logic                  done,
    input  logic [RES_W-1:0]      res_data,
    input  logic                  res_valid,
    output logic                  res_ready,
    output logic [ADDR_W-1:0]     gbus_waddr,
    output logic [RES_W*PACK-1:0] gbus_wdata,
    output logic [PACK-1:0]       gbus_wmask,
    output logic                  gbus_wvalid,
    input  logic                  gbus_wready
);

    localparam int LW    = idx_w(PACK);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = ADDR_W + RES_W * PACK + PACK;

    state_t                  state_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    push_pend_q;
    logic [ADDR_W-1:0]       base_q;
    logic [ADDR_W-1:0]       widx_q;
    logic [15:0]             len_q;
    logic [15:0]             rcnt_q;
    logic [LW-1:0]           lane_q;
    logic [RES_W*PACK-1:0]   pack_dat_q;
    logic [PACK-1:0]         pack_msk_q;

    logic [CW-1:0]           fifo_cnt;
    logic                    fifo_empty;
    logic [ENT_W-1:0]        push_dat;
    logic [ENT_W-1:0]        head_dat;
    logic                    accept;
    logic                    last_res;
    logic                    word_full;

    // Holding off new results while a completed word waits to be pushed keeps the
    // pack register single-buffered and guarantees the FIFO has room for that push.
    assign res_ready = (state_q == ST_RUN) && !push_pend_q && (fifo_cnt < CW'(FIFO_DEPTH));
    assign accept    = res_valid && res_ready;
    assign last_res  = ((rcnt_q + 16'd1) == len_q);
    assign word_full = (lane_q == LW'(PACK - 1));
    assign push_dat  = {base_q + widx_q, pack_dat_q, pack_msk_q};

    assign busy        = busy_q;
    assign done        = done_q;
    assign gbus_wvalid = !fifo_empty;
    assign {gbus_waddr, gbus_wdata, gbus_wmask} = gbus_wvalid ? head_dat : '0;

    core_wfifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wfifo (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .push_i     (push_pend_q),
        .push_dat_i (push_dat),
        .pop_i      (gbus_wvalid && gbus_wready),
        .head_dat_o (head_dat),
        .count_o    (fifo_cnt),
        .empty_o    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            push_pend_q <= 1'b0;
            base_q      <= '0;
            widx_q      <= '0;
            len_q       <= '0;
            rcnt_q      <= '0;
            lane_q      <= '0;
            pack_dat_q  <= '0;
            pack_msk_q  <= '0;
        end else begin
            if (push_pend_q) begin
                push_pend_q <= 1'b0;
                pack_dat_q  <= '0;
                pack_msk_q  <= '0;
                widx_q      <= widx_q + ADDR_W'(1);
            end

            if (accept) begin
                pack_dat_q[lane_q*RES_W +: RES_W] <= res_data;
                pack_msk_q[lane_q]                <= 1'b1;
                rcnt_q                            <= rcnt_q + 16'd1;
                lane_q                            <= word_full ? '0 : lane_q + LW'(1);
                if (word_full || last_res) begin
                    push_pend_q <= 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        len_q   <= len;
                        rcnt_q  <= '0;
                        widx_q  <= '0;
                        lane_q  <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= (len == 16'd0);
                        state_q <= (len == 16'd0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept && last_res) begin
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (!push_pend_q && (pack_msk_q == '0) && fifo_empty) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_acc_writer.sv
// Randomized and directed bench for core_acc_writer against a word-level write model.
module tb_core_acc_writer;

    localparam int PACK       = 4;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [9:0]  a;
        logic [63:0] d;
        logic [3:0]  m;
    } wr_t;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [9:0]  base_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic [15:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic [9:0]  gbus_waddr;
    logic [63:0] gbus_wdata;
    logic [3:0]  gbus_wmask;
    logic        gbus_wvalid;
    logic        gbus_wready;

    int  n_tests  = 0;
    int  n_fail   = 0;
    int  done_cnt = 0;
    wr_t exp_q[$];
    wr_t prev;
    wr_t got;
    bit  prev_stall = 1'b0;

    core_acc_writer dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .base_addr   (base_addr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .res_data    (res_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .gbus_waddr  (gbus_waddr),
        .gbus_wdata  (gbus_wdata),
        .gbus_wmask  (gbus_wmask),
        .gbus_wvalid (gbus_wvalid),
        .gbus_wready (gbus_wready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},   busy,        0);
        chk({tag, "_done"},   done,        0);
        chk({tag, "_rdy"},    res_ready,   0);
        chk({tag, "_wvalid"}, gbus_wvalid, 0);
        chk({tag, "_waddr"},  gbus_waddr,  0);
        chk({tag, "_wdata"},  gbus_wdata,  0);
        chk({tag, "_wmask"},  gbus_wmask,  0);
    endtask

    // Write-side monitor: every accepted write must match the next modelled word,
    // and a stalled head must not change.
    always @(negedge clk) begin
        if (rstn) begin
            if (prev_stall) begin
                chk("hold_vld",  gbus_wvalid, 1);
                chk("hold_addr", gbus_waddr,  prev.a);
                chk("hold_data", gbus_wdata,  prev.d);
                chk("hold_mask", gbus_wmask,  prev.m);
            end
            if (gbus_wvalid && gbus_wready) begin
                chk("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    got = exp_q.pop_front();
                    chk("write_addr", gbus_waddr, got.a);
                    chk("write_data", gbus_wdata, got.d);
                    chk("write_mask", gbus_wmask, got.m);
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_writes_left", exp_q.size(), 0);
                chk("done_busy", busy, 1);
                chk("done_no_wvalid", gbus_wvalid, 0);
            end
            prev_stall = gbus_wvalid && !gbus_wready;
            prev.a     = gbus_waddr;
            prev.d     = gbus_wdata;
            prev.m     = gbus_wmask;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic xfer(input logic [9:0] b, input int n, input bit seq,
                        input int vld_pct, input int rdy_pct, input int stall);
        logic [15:0] vals[$];
        wr_t         e;
        int          n_acc = 0;
        int          cyc   = 0;
        int          d0;
        int          cap;
        for (int i = 0; i < n; i++) begin
            vals.push_back(seq ? 16'(i + 1) : 16'($urandom));
        end
        for (int w = 0; w < (n + PACK - 1) / PACK; w++) begin
            e.a = 10'(int'(b) + w);
            e.d = '0;
            e.m = '0;
            for (int l = 0; l < PACK; l++) begin
                if (w * PACK + l < n) begin
                    e.d[l*16 +: 16] = vals[w * PACK + l];
                    e.m[l]          = 1'b1;
                end
            end
            exp_q.push_back(e);
        end
        cap = (n < FIFO_DEPTH * PACK) ? n : FIFO_DEPTH * PACK;
        d0  = done_cnt;

        start     = 1'b1;
        base_addr = b;
        len       = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
        while (done_cnt == d0 && cyc < 3000) begin
            res_valid   = (vals.size() > 0) && ($urandom_range(99) < vld_pct);
            res_data    = (vals.size() > 0) ? vals[0] : 16'h0;
            gbus_wready = (cyc >= stall) && ($urandom_range(99) < rdy_pct);
            // A start arriving mid-transfer must be ignored, base/len included.
            start       = (cyc == 3);
            base_addr   = 10'($urandom);
            len         = 16'hFFFF;
            @(negedge clk);
            if (stall > 0 && cyc == stall) begin
                chk("stall_accepted", n_acc, cap);
                chk("stall_rdy_low", res_ready, 0);
                chk("stall_wvalid", gbus_wvalid, 1);
            end
            if (res_valid && res_ready) begin
                void'(vals.pop_front());
                n_acc++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("xfer_done_seen", done_cnt - d0, 1);
        chk("xfer_accepted", n_acc, n);
        chk("xfer_writes_left", exp_q.size(), 0);
        res_valid   = 1'b0;
        gbus_wready = 1'b0;
        start       = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("xfer_single_done", done_cnt - d0, 1);
        chk("xfer_idle_busy", busy, 0);
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, %0d checks so far", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rstn        = 1'b0;
        start       = 1'b0;
        base_addr   = '0;
        len         = '0;
        res_data    = '0;
        res_valid   = 1'b0;
        gbus_wready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rstn = 1'b1;
        @(posedge clk); #1;

        xfer(10'h010, 8, 1'b1, 100, 100, 0);
        xfer(10'h030, 6, 1'b1, 100, 100, 0);
        xfer(10'h050, 24, 1'b0, 100, 100, 40);

        d0        = done_cnt;
        start     = 1'b1;
        base_addr = 10'h005;
        len       = 16'd0;
        @(negedge clk);
        chk("len0_busy_before", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 1);
        chk("len0_wvalid", gbus_wvalid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("len0_done_after", done, 0);
        chk("len0_busy_after", busy, 0);
        chk("len0_wvalid_after", gbus_wvalid, 0);
        chk("len0_done_count", done_cnt - d0, 1);
        @(posedge clk); #1;

        xfer(10'h3FF, 8, 1'b0, 100, 100, 0);

        start     = 1'b1;
        base_addr = 10'h040;
        len       = 16'd8;
        @(posedge clk); #1;
        start       = 1'b0;
        res_valid   = 1'b1;
        gbus_wready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            res_data = 16'(i + 100);
            @(posedge clk); #1;
        end
        rstn = 1'b0;
        @(posedge clk); #1;
        chk_idle_outputs("midrst");
        d0        = done_cnt;
        rstn      = 1'b1;
        res_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_idle", busy, 0);
        xfer(10'h020, 4, 1'b1, 100, 100, 0);

        for (int t = 0; t < 12; t++) begin
            xfer(10'($urandom), int'($urandom_range(1, 20)), 1'b0,
                 int'($urandom_range(30, 100)), int'($urandom_range(20, 100)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
